// File: rtl/sum_display_scanner.sv
// sum_display_scanner: shows adder operands A, B (hex) and the 5-bit sum {C,Y}
// (two decimal digits) on the Basys3 4-digit 7-segment display. Inputs are
// snapshotted once per scan frame so a frame never mixes old and new values.
`timescale 1ns/1ps
module sum_display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] Y,
    input  logic       C,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam logic [3:0] AN_BLANK  = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segment pattern for one hex digit, seg[0]=a ... seg[6]=g.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'b1000000;
            4'h1: p = 7'b1111001;
            4'h2: p = 7'b0100100;
            4'h3: p = 7'b0110000;
            4'h4: p = 7'b0011001;
            4'h5: p = 7'b0010010;
            4'h6: p = 7'b0000010;
            4'h7: p = 7'b1111000;
            4'h8: p = 7'b0000000;
            4'h9: p = 7'b0010000;
            4'hA: p = 7'b0001000;
            4'hB: p = 7'b0000011;
            4'hC: p = 7'b1000110;
            4'hD: p = 7'b0100001;
            4'hE: p = 7'b0000110;
            default: p = 7'b0001110;
        endcase
        return p;
    endfunction

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             primed_q, primed_d;
    logic [3:0]       snap_a_q, snap_a_d;
    logic [3:0]       snap_b_q, snap_b_d;
    logic [3:0]       snap_y_q, snap_y_d;
    logic             snap_c_q, snap_c_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic             tick;
    logic [4:0]       sum;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic [3:0]       digit;

    // Divider terminal count; the divider only runs once the snapshot is primed.
    assign tick = primed_q && (div_cnt_q == CNT_W'(REFRESH_DIV - 1));

    // Counter, digit index and snapshot next-state; snapshot reloads at frame boundary only.
    always_comb begin
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        primed_d  = primed_q;
        snap_a_d  = snap_a_q;
        snap_b_d  = snap_b_q;
        snap_y_d  = snap_y_q;
        snap_c_d  = snap_c_q;
        if (!primed_q) begin
            primed_d = 1'b1;
            snap_a_d = A;
            snap_b_d = B;
            snap_y_d = Y;
            snap_c_d = C;
        end else if (tick) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                snap_a_d = A;
                snap_b_d = B;
                snap_y_d = Y;
                snap_c_d = C;
            end
        end else begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
        end
    end

    // Split the 0..31 snapshot sum into decimal tens and ones.
    always_comb begin
        sum = {snap_c_q, snap_y_q};
        if (sum >= 5'd30) begin
            tens = 4'd3;
            ones = 4'(sum - 5'd30);
        end else if (sum >= 5'd20) begin
            tens = 4'd2;
            ones = 4'(sum - 5'd20);
        end else if (sum >= 5'd10) begin
            tens = 4'd1;
            ones = 4'(sum - 5'd10);
        end else begin
            tens = 4'd0;
            ones = sum[3:0];
        end
    end

    // Pick the digit for the current slot and form the anode/segment pattern.
    always_comb begin
        an_d  = AN_BLANK;
        seg_d = SEG_BLANK;
        case (idx_q)
            2'd0:    digit = ones;
            2'd1:    digit = tens;
            2'd2:    digit = snap_b_q;
            default: digit = snap_a_q;
        endcase
        if (primed_q && !(idx_q == 2'd1 && tens == 4'd0)) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = hex7(digit);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            idx_q     <= 2'd0;
            primed_q  <= 1'b0;
            snap_a_q  <= 4'd0;
            snap_b_q  <= 4'd0;
            snap_y_q  <= 4'd0;
            snap_c_q  <= 1'b0;
            an_q      <= AN_BLANK;
            seg_q     <= SEG_BLANK;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            primed_q  <= primed_d;
            snap_a_q  <= snap_a_d;
            snap_b_q  <= snap_b_d;
            snap_y_q  <= snap_y_d;
            snap_c_q  <= snap_c_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule
